// File: rtl/clock_enable_manager.sv
// PLL lock qualifier with core reset sequencing, lock-loss counting and
// NUM_CH runtime-programmable clock-enable strobes, all in the PLL output domain.
module clock_enable_manager #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned LOCK_WAIT   = 16,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned DEFAULT_DIV = 1,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pllLocked,
    output logic                 coreReset,
    output logic                 isRunning,
    output logic [NUM_CH-1:0]    clkEnable,
    input  logic                 cfgValid,
    input  logic [CH_W-1:0]      cfgChannel,
    input  logic [DIV_WIDTH-1:0] cfgDivisor,
    output logic [CNT_WIDTH-1:0] lossCount
);

    localparam int unsigned WAIT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [WAIT_W-1:0]    WaitLast = WAIT_W'(LOCK_WAIT - 1);
    localparam logic [DIV_WIDTH-1:0] DefDiv   = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StRun
    } state_e;

    state_e                state_q, state_d;
    logic                  s1_q, lock_sync_q;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]  loss_cnt_q, loss_cnt_d;

    logic [DIV_WIDTH-1:0]  act_div_q  [NUM_CH];
    logic [DIV_WIDTH-1:0]  act_div_d  [NUM_CH];
    logic [DIV_WIDTH-1:0]  pend_div_q [NUM_CH];
    logic [DIV_WIDTH-1:0]  pend_div_d [NUM_CH];
    logic [DIV_WIDTH-1:0]  cnt_q      [NUM_CH];
    logic [DIV_WIDTH-1:0]  cnt_d      [NUM_CH];

    logic                  run;
    logic                  enter_run;
    logic                  cfg_hit;
    logic [DIV_WIDTH-1:0]  pend_nxt;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        loss_cnt_d = loss_cnt_q;
        unique case (state_q)
            StWaitLock: begin
                if (lock_sync_q) begin
                    state_d    = StStable;
                    wait_cnt_d = '0;
                end
            end
            StStable: begin
                // A drop while qualifying is not a loss; qualification simply restarts.
                if (!lock_sync_q) begin
                    state_d = StWaitLock;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StRun;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            StRun: begin
                if (!lock_sync_q) begin
                    state_d = StWaitLock;
                    if (loss_cnt_q != '1) begin
                        loss_cnt_d = loss_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    assign run       = (state_q == StRun);
    assign enter_run = (state_d == StRun) && !run;

    always_comb begin
        clkEnable = '0;
        cfg_hit   = 1'b0;
        pend_nxt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit       = cfgValid && (32'(cfgChannel) < NUM_CH) && (cfgChannel == CH_W'(i));
            // Write bypass: a write landing on the wrap cycle is used by that wrap.
            pend_nxt      = cfg_hit ? cfgDivisor : pend_div_q[i];
            pend_div_d[i] = pend_nxt;
            act_div_d[i]  = act_div_q[i];
            cnt_d[i]      = cnt_q[i];
            if (!run) begin
                if (cfg_hit) begin
                    act_div_d[i] = cfgDivisor;
                end
                if (enter_run) begin
                    cnt_d[i] = '0;
                end
            end else if (cnt_q[i] == '0) begin
                clkEnable[i] = 1'b1;
                act_div_d[i] = pend_nxt;
                cnt_d[i]     = (pend_nxt == '0) ? '0 : pend_nxt - DIV_WIDTH'(1);
            end else begin
                cnt_d[i] = cnt_q[i] - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 1'b0;
            lock_sync_q <= 1'b0;
            state_q     <= StWaitLock;
            wait_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                act_div_q[i]  <= DefDiv;
                pend_div_q[i] <= DefDiv;
                cnt_q[i]      <= '0;
            end
        end else begin
            s1_q        <= pllLocked;
            lock_sync_q <= s1_q;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                act_div_q[i]  <= act_div_d[i];
                pend_div_q[i] <= pend_div_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
        end
    end

    assign coreReset = !run;
    assign isRunning = run;
    assign lossCount = loss_cnt_q;

endmodule

// File: tb/tb_clock_enable_manager.sv
// Scenario bench for clock_enable_manager: lock qualification, divider ratios,
// pending/bypass writes, lock loss, STABLE glitch and mid-RUN reset.
module tb_clock_enable_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic       pllLocked;
    logic       cfgValid;
    logic [1:0] cfgChannel;
    logic [7:0] cfgDivisor;
    logic       coreReset;
    logic       isRunning;
    logic [3:0] clkEnable;
    logic [3:0] lossCount;

    logic       cfg_valid5;
    logic [2:0] cfg_channel5;
    logic       core_reset5;
    logic       is_running5;
    logic [4:0] clk_enable5;
    logic [3:0] loss_count5;

    int checks = 0;
    int errors = 0;
    int exp_loss = 0;

    typedef struct packed {
        logic [4:0] val;
        logic [4:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   loss_q[$];

    always #5 clk = ~clk;

    clock_enable_manager #(
        .NUM_CH(4), .DIV_WIDTH(8), .LOCK_WAIT(4), .CNT_WIDTH(4), .DEFAULT_DIV(1)
    ) u_dut (
        .clk(clk), .reset(reset), .pllLocked(pllLocked),
        .coreReset(coreReset), .isRunning(isRunning), .clkEnable(clkEnable),
        .cfgValid(cfgValid), .cfgChannel(cfgChannel), .cfgDivisor(cfgDivisor),
        .lossCount(lossCount)
    );

    // Five channels so that an out-of-range index (5..7) is representable.
    clock_enable_manager #(
        .NUM_CH(5), .DIV_WIDTH(8), .LOCK_WAIT(4), .CNT_WIDTH(4), .DEFAULT_DIV(1)
    ) u_dut5 (
        .clk(clk), .reset(reset), .pllLocked(pllLocked),
        .coreReset(core_reset5), .isRunning(is_running5), .clkEnable(clk_enable5),
        .cfgValid(cfg_valid5), .cfgChannel(cfg_channel5), .cfgDivisor(cfgDivisor),
        .lossCount(loss_count5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pllLocked = 1'b0; cfgValid = 1'b0; cfgChannel = '0; cfgDivisor = '0;
        cfg_valid5 = 1'b0; cfg_channel5 = '0;
        step();
        step();
        checks++;
        if (coreReset !== 1'b1) begin
            errors++; $display("FAIL reset_core_reset got %b want 1", coreReset);
        end
        checks++;
        if (isRunning !== 1'b0) begin
            errors++; $display("FAIL reset_is_running got %b want 0", isRunning);
        end
        checks++;
        if (clkEnable !== 4'h0) begin
            errors++; $display("FAIL reset_clk_enable got %h want 0", clkEnable);
        end
        checks++;
        if (lossCount !== 4'h0) begin
            errors++; $display("FAIL reset_loss_count got %0d want 0", lossCount);
        end
    endtask

    task automatic test_lockup();
        logic exp_cr;
        reset = 1'b0;
        pllLocked = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            step();
            exp_cr = (i < 6);
            checks++;
            if (coreReset !== exp_cr || isRunning !== !exp_cr) begin
                errors++;
                $display("FAIL lockup_core_reset E%0d got %b/%b want %b/%b", i, coreReset,
                         isRunning, exp_cr, !exp_cr);
            end
        end
        checks++;
        if (clkEnable !== 4'hF) begin
            errors++; $display("FAIL lockup_first_strobe got %h want f", clkEnable);
        end
        checks++;
        if (clk_enable5 !== 5'h1F) begin
            errors++; $display("FAIL lockup_first_strobe5 got %h want 1f", clk_enable5);
        end
        checks++;
        if (lossCount !== 4'h0) begin
            errors++; $display("FAIL lockup_loss_count got %0d want 0", lossCount);
        end
    endtask

    // Writes in RUN cycles 0,1,2: ch1=3, ch2=0, ch3=5; each lands on a D=1 wrap.
    task automatic test_divider_ratios();
        exp_t e;
        logic c1, c3;
        for (int t = 1; t <= 60; t++) begin
            c1 = (t % 3 == 0);
            c3 = (t <= 2) || ((t - 2) % 5 == 0);
            exp_q.push_back('{val: {1'b0, c3, 1'b1, c1, 1'b1}, mask: 5'b01111});
        end
        for (int i = 0; i < 60; i++) begin
            cfgValid = (i < 3);
            cfgChannel = 2'(i + 1);
            cfgDivisor = (i == 0) ? 8'd3 : (i == 1) ? 8'd0 : 8'd5;
            step();
            e = exp_q.pop_front();
            checks++;
            if ((({1'b0, clkEnable} ^ e.val) & e.mask) !== 5'b0) begin
                errors++;
                $display("FAIL divider_ratio t=%0d got %b want %b", i + 1, clkEnable, e.val[3:0]);
            end
        end
        cfgValid = 1'b0;
    endtask

    // ch0: D=4 at cycle 0 (bypass), D=2 two cycles before the wrap at 8, D=6 on the wrap at 12.
    task automatic test_pending_bypass();
        exp_t e;
        logic s;
        for (int t = 1; t <= 30; t++) begin
            s = (t == 4) || (t == 8) || (t == 10) || (t == 12) || (t == 18) || (t == 24) ||
                (t == 30);
            exp_q.push_back('{val: {4'b0, s}, mask: 5'b00001});
        end
        for (int i = 0; i < 30; i++) begin
            cfgValid = (i == 0) || (i == 6) || (i == 12);
            cfgChannel = 2'd0;
            cfgDivisor = (i == 0) ? 8'd4 : (i == 6) ? 8'd2 : 8'd6;
            step();
            e = exp_q.pop_front();
            checks++;
            if ((({1'b0, clkEnable} ^ e.val) & e.mask) !== 5'b0) begin
                errors++;
                $display("FAIL pending_bypass t=%0d got %b want %b", i + 1, clkEnable[0], e.val[0]);
            end
        end
        cfgValid = 1'b0;
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic s4;
        for (int t = 1; t <= 12; t++) begin
            s4 = (t <= 5) || ((t - 5) % 2 == 0);
            exp_q.push_back('{val: {s4, 4'hF}, mask: 5'h1F});
        end
        for (int i = 0; i < 12; i++) begin
            cfg_valid5 = (i < 3) || (i == 5);
            cfg_channel5 = (i == 5) ? 3'd4 : 3'(5 + i);
            cfgDivisor = (i == 5) ? 8'd2 : 8'd3;
            step();
            e = exp_q.pop_front();
            checks++;
            if (((clk_enable5 ^ e.val) & e.mask) !== 5'b0) begin
                errors++;
                $display("FAIL out_of_range t=%0d got %b want %b", i + 1, clk_enable5, e.val);
            end
        end
        cfg_valid5 = 1'b0;
    endtask

    task automatic test_lock_loss(input int n);
        logic exp_cr;
        int   want;
        for (int k = 0; k < n; k++) begin
            pllLocked = 1'b0;
            if (exp_loss < 15) exp_loss++;
            loss_q.push_back(exp_loss);
            step();
            pllLocked = 1'b1;
            checks++;
            if (coreReset !== 1'b0) begin
                errors++; $display("FAIL loss_early_F k=%0d got %b want 0", k, coreReset);
            end
            step();
            checks++;
            if (coreReset !== 1'b0) begin
                errors++; $display("FAIL loss_early_F1 k=%0d got %b want 0", k, coreReset);
            end
            step();
            want = loss_q.pop_front();
            checks++;
            if (coreReset !== 1'b1 || isRunning !== 1'b0 || clkEnable !== 4'h0) begin
                errors++;
                $display("FAIL loss_outputs k=%0d got cr=%b run=%b en=%h want 1 0 0", k,
                         coreReset, isRunning, clkEnable);
            end
            checks++;
            if (lossCount !== 4'(want)) begin
                errors++; $display("FAIL loss_count k=%0d got %0d want %0d", k, lossCount, want);
            end
            for (int j = 3; j <= 7; j++) begin
                step();
                exp_cr = (j < 7);
                checks++;
                if (coreReset !== exp_cr) begin
                    errors++;
                    $display("FAIL loss_requal k=%0d F+%0d got %b want %b", k, j, coreReset, exp_cr);
                end
            end
            checks++;
            if (clkEnable !== 4'hF) begin
                errors++; $display("FAIL loss_first_strobe k=%0d got %h want f", k, clkEnable);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        logic exp_cr;
        reset = 1'b1;
        cfgValid = 1'b1; cfgChannel = 2'd1; cfgDivisor = 8'd3;
        step();
        exp_loss = 0;
        checks++;
        if (coreReset !== 1'b1 || isRunning !== 1'b0 || clkEnable !== 4'h0 ||
            lossCount !== 4'h0) begin
            errors++;
            $display("FAIL midrun_reset got cr=%b run=%b en=%h loss=%0d want 1 0 0 0", coreReset,
                     isRunning, clkEnable, lossCount);
        end
        step();
        reset = 1'b0;
        cfgValid = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            step();
            exp_cr = (i < 6);
            checks++;
            if (coreReset !== exp_cr) begin
                errors++;
                $display("FAIL midrun_requal E%0d got %b want %b", i, coreReset, exp_cr);
            end
        end
        exp_q.push_back('{val: 5'h0F, mask: 5'h0F});
        for (int t = 1; t <= 20; t++) exp_q.push_back('{val: 5'h0F, mask: 5'h0F});
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) step();
            e = exp_q.pop_front();
            checks++;
            if ((({1'b0, clkEnable} ^ e.val) & e.mask) !== 5'b0) begin
                errors++;
                $display("FAIL midrun_default_div t=%0d got %h want %h", t, clkEnable, e.val[3:0]);
            end
        end
    endtask

    task automatic test_glitch_stable();
        logic exp_cr;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            if (i == 2) pllLocked = 1'b0;
            if (i == 3) pllLocked = 1'b1;
            exp_cr = (i < 10);
            checks++;
            if (coreReset !== exp_cr) begin
                errors++; $display("FAIL glitch_requal E%0d got %b want %b", i, coreReset, exp_cr);
            end
        end
        checks++;
        if (lossCount !== 4'h0) begin
            errors++; $display("FAIL glitch_loss_count got %0d want 0", lossCount);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lockup();
        test_divider_ratios();
        test_pending_bypass();
        test_out_of_range();
        test_lock_loss(2);
        test_reset_mid_run();
        test_glitch_stable();
        test_lock_loss(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
